// File: rtl/hex_key_entry_if.sv
// Keypad entry bundle: keycode and qualifiers toward the entry block,
// live entry buffer plus one-cycle submit/reject pulses back to the quiz FSM.
interface hex_key_entry_if #(
  parameter int MAX_DIGITS = 2
);
  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [7:0]    keycode;
  logic          enable;
  logic          clear;
  logic [W-1:0]  entry;
  logic [CW-1:0] digit_count;
  logic [W-1:0]  result;
  logic          submit;
  logic          reject;

  modport master (
    output keycode, enable, clear,
    input  entry, digit_count, result, submit, reject
  );

  modport slave (
    input  keycode, enable, clear,
    output entry, digit_count, result, submit, reject
  );
endinterface

// File: rtl/hex_key_entry.sv
// Qualifies HID keycodes and edits a hex answer buffer; a key acts on its STABLE_CYCLES-th equal sample.
// Latency: all outputs registered; no backpressure, submit/reject are single-cycle pulses.
module hex_key_entry #(
  parameter int MAX_DIGITS    = 2,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset_n,
  hex_key_entry_if.slave kif
);
  localparam int W     = 4 * MAX_DIGITS;
  localparam int CW    = $clog2(MAX_DIGITS + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]    MAX_CNT  = CW'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_BS    = 8'h2A;

  typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

  state_t           state;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     entry;
  logic [W-1:0]     result;
  logic [CW-1:0]    digit_count;
  logic             submit;
  logic             reject;

  logic       is_hex;
  logic [3:0] hex_val;
  logic       fire;

  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'h0;
    if (kif.keycode >= 8'h04 && kif.keycode <= 8'h09) begin
      is_hex  = 1'b1;
      hex_val = 4'(kif.keycode + 8'h06);
    end else if (kif.keycode >= 8'h1E && kif.keycode <= 8'h26) begin
      is_hex  = 1'b1;
      hex_val = 4'(kif.keycode - 8'h1D);
    end else if (kif.keycode == 8'h27) begin
      is_hex  = 1'b1;
      hex_val = 4'h0;
    end
  end

  // cand is always nonzero in QUAL, so a match also implies a key is down.
  assign fire = (state == QUAL) && (kif.keycode == cand) && ((cnt + CNT_W'(1)) == STABLE_N);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= 8'h00;
      cnt         <= '0;
      entry       <= '0;
      result      <= '0;
      digit_count <= '0;
      submit      <= 1'b0;
      reject      <= 1'b0;
    end else begin
      submit <= 1'b0;
      reject <= 1'b0;

      case (state)
        IDLE: begin
          if (kif.keycode != 8'h00) begin
            state <= QUAL;
            cand  <= kif.keycode;
            cnt   <= CNT_W'(1);
          end
        end
        QUAL: begin
          if (kif.keycode == 8'h00) begin
            state <= IDLE;
          end else if (kif.keycode != cand) begin
            cand <= kif.keycode;
            cnt  <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fire) state <= HELD;
          end
        end
        HELD: begin
          if (kif.keycode == 8'h00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // clear wins over a coinciding action; the key is still consumed above.
      if (kif.clear) begin
        entry       <= '0;
        digit_count <= '0;
      end else if (fire && kif.enable) begin
        if (is_hex) begin
          if (digit_count < MAX_CNT) begin
            entry       <= (entry << 4) | W'(hex_val);
            digit_count <= digit_count + CW'(1);
          end else begin
            reject <= 1'b1;
          end
        end else if (kif.keycode == KC_BS) begin
          if (digit_count != '0) begin
            entry       <= entry >> 4;
            digit_count <= digit_count - CW'(1);
          end else begin
            reject <= 1'b1;
          end
        end else if (kif.keycode == KC_ESC) begin
          entry       <= '0;
          digit_count <= '0;
        end else if (kif.keycode == KC_ENTER) begin
          if (digit_count != '0) begin
            result      <= entry;
            submit      <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
          end else begin
            reject <= 1'b1;
          end
        end
      end
    end
  end

  assign kif.entry       = entry;
  assign kif.digit_count = digit_count;
  assign kif.result      = result;
  assign kif.submit      = submit;
  assign kif.reject      = reject;

endmodule

// File: tb/tb_hex_key_entry.sv
// Bench for hex_key_entry: directed table, hand-written corner sequences, then random keys vs a digit-queue model.
module tb_hex_key_entry;
  localparam int MAXD = 2;
  localparam int STAB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_key_entry_if #(.MAX_DIGITS(MAXD)) kif();

  hex_key_entry #(.MAX_DIGITS(MAXD), .STABLE_CYCLES(STAB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] kc;
    logic       en;
    logic       clr;
    logic       rst_n;
    logic [7:0] e_entry;
    logic [1:0] e_cnt;
    logic [7:0] e_res;
    logic       e_sub;
    logic       e_rej;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic [7:0] kc, input logic en, input logic clr, input logic rst);
    kif.keycode = kc;
    kif.enable  = en;
    kif.clear   = clr;
    reset_n     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [7:0] ee, input logic [1:0] ec,
                           input logic [7:0] er, input logic es, input logic ej);
    n_chk++;
    if ({kif.entry, kif.digit_count, kif.result, kif.submit, kif.reject} !== {ee, ec, er, es, ej}) begin
      n_fail++;
      $display("FAIL %s: got entry=%h cnt=%0d result=%h submit=%b reject=%b, want entry=%h cnt=%0d result=%h submit=%b reject=%b",
               name, kif.entry, kif.digit_count, kif.result, kif.submit, kif.reject, ee, ec, er, es, ej);
    end
  endtask

  task automatic add(input logic [7:0] kc, input logic en, input logic clr, input logic rst,
                     input logic [7:0] ee, input logic [1:0] ec, input logic [7:0] er,
                     input logic es, input logic ej);
    vec_t v;
    v = '{kc: kc, en: en, clr: clr, rst_n: rst, e_entry: ee, e_cnt: ec, e_res: er, e_sub: es, e_rej: ej};
    tbl.push_back(v);
  endtask

  // Hold a key n cycles then release; it acts on the STAB-th sample.
  task automatic add_hold(input logic [7:0] kc, input int n,
                          input logic [7:0] pe, input logic [1:0] pc, input logic [7:0] pr,
                          input logic [7:0] qe, input logic [1:0] qc, input logic [7:0] qr,
                          input logic es, input logic ej);
    for (int i = 1; i <= n; i++) begin
      if (i < STAB)       add(kc, 1'b1, 1'b0, 1'b1, pe, pc, pr, 1'b0, 1'b0);
      else if (i == STAB) add(kc, 1'b1, 1'b0, 1'b1, qe, qc, qr, es, ej);
      else                add(kc, 1'b1, 1'b0, 1'b1, qe, qc, qr, 1'b0, 1'b0);
    end
    add(8'h00, 1'b1, 1'b0, 1'b1, qe, qc, qr, 1'b0, 1'b0);
  endtask

  task automatic hs(input string name, input logic [7:0] kc, input logic en, input logic clr,
                    input logic rst, input logic [7:0] ee, input logic [1:0] ec,
                    input logic [7:0] er, input logic es, input logic ej);
    drive(kc, en, clr, rst);
    check_out(name, ee, ec, er, es, ej);
  endtask

  // Reference model: press qualification by run length, entry kept as a digit queue (oldest first).
  int         m_run;
  logic [7:0] m_last;
  bit         m_held;
  logic [3:0] m_q[$];
  logic [7:0] m_res;
  bit         m_sub, m_rej;

  function automatic int hex_of(input logic [7:0] kc);
    if (kc >= 8'h04 && kc <= 8'h09) return int'(kc) - 4 + 10;
    if (kc >= 8'h1E && kc <= 8'h26) return int'(kc) - 'h1E + 1;
    if (kc == 8'h27) return 0;
    return -1;
  endfunction

  function automatic logic [7:0] m_val();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + int'(m_q[i]);
    return 8'(v);
  endfunction

  task automatic model_step(input logic [7:0] kc, input logic en, input logic clr, input logic rst);
    bit act;
    int d;
    act   = 1'b0;
    m_sub = 1'b0;
    m_rej = 1'b0;
    if (!rst) begin
      m_run = 0; m_last = 8'h00; m_held = 1'b0; m_q.delete(); m_res = 8'h00;
      return;
    end
    if (m_held) begin
      if (kc == 8'h00) begin m_held = 1'b0; m_run = 0; end
    end else if (kc == 8'h00) begin
      m_run = 0;
    end else begin
      m_run  = (kc == m_last && m_run > 0) ? m_run + 1 : 1;
      m_last = kc;
      if (m_run == STAB) begin act = 1'b1; m_held = 1'b1; end
    end
    if (clr) begin
      m_q.delete();
    end else if (act && en) begin
      d = hex_of(kc);
      if (d >= 0) begin
        if (m_q.size() < MAXD) m_q.push_back(4'(d));
        else m_rej = 1'b1;
      end else if (kc == 8'h2A) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else m_rej = 1'b1;
      end else if (kc == 8'h29) begin
        m_q.delete();
      end else if (kc == 8'h28) begin
        if (m_q.size() > 0) begin m_res = m_val(); m_sub = 1'b1; m_q.delete(); end
        else m_rej = 1'b1;
      end
    end
  endtask

  logic [7:0] pool[15] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h07, 8'h09, 8'h1E, 8'h22,
                           8'h27, 8'h28, 8'h29, 8'h2A, 8'h2A, 8'h55, 8'hE0};

  initial begin
    logic [7:0] kc;
    logic en, clr, rst;

    kif.keycode = 8'h00;
    kif.enable  = 1'b1;
    kif.clear   = 1'b0;

    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    add_hold(8'h1E, 4, 8'h00, 2'd0, 8'h00, 8'h01, 2'd1, 8'h00, 1'b0, 1'b0);
    add_hold(8'h06, 6, 8'h01, 2'd1, 8'h00, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b0);
    add(8'h1E, 1'b1, 1'b0, 1'b1, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b1, 1'b0, 1'b1, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(8'h1E, 1'b1, 1'b0, 1'b1, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b0);
    add(8'h00, 1'b1, 1'b0, 1'b1, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b0);
    add_hold(8'h1E, 4, 8'h1C, 2'd2, 8'h00, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b1);
    add_hold(8'h27, 4, 8'h1C, 2'd2, 8'h00, 8'h1C, 2'd2, 8'h00, 1'b0, 1'b1);
    add_hold(8'h2A, 4, 8'h1C, 2'd2, 8'h00, 8'h01, 2'd1, 8'h00, 1'b0, 1'b0);
    add_hold(8'h2A, 4, 8'h01, 2'd1, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    add_hold(8'h2A, 4, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 8'h00, 1'b0, 1'b1);
    add_hold(8'h20, 4, 8'h00, 2'd0, 8'h00, 8'h03, 2'd1, 8'h00, 1'b0, 1'b0);
    add_hold(8'h09, 4, 8'h03, 2'd1, 8'h00, 8'h3F, 2'd2, 8'h00, 1'b0, 1'b0);
    add_hold(8'h28, 4, 8'h3F, 2'd2, 8'h00, 8'h00, 2'd0, 8'h3F, 1'b1, 1'b0);
    add_hold(8'h28, 4, 8'h00, 2'd0, 8'h3F, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      drive(tbl[i].kc, tbl[i].en, tbl[i].clr, tbl[i].rst_n);
      check_out($sformatf("tbl[%0d]", i), tbl[i].e_entry, tbl[i].e_cnt, tbl[i].e_res,
                tbl[i].e_sub, tbl[i].e_rej);
    end

    // Key stabilises while disabled, enable rises mid-hold: consumed, no action.
    for (int i = 0; i < 4; i++) hs("gate_off", 8'h04, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hs("gate_rise", 8'h04, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    hs("gate_rel", 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hs("repress_pre", 8'h04, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    hs("repress_act", 8'h04, 1'b1, 1'b0, 1'b1, 8'h0A, 2'd1, 8'h3F, 1'b0, 1'b0);
    hs("repress_rel", 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 2'd1, 8'h3F, 1'b0, 1'b0);

    // clear on the ENTER action edge suppresses submit and still consumes the key.
    for (int i = 0; i < 3; i++) hs("clr_pre", 8'h28, 1'b1, 1'b0, 1'b1, 8'h0A, 2'd1, 8'h3F, 1'b0, 1'b0);
    hs("clr_act", 8'h28, 1'b1, 1'b1, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hs("clr_held", 8'h28, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    hs("clr_rel", 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);

    // Reset while a key is held; the key is re-qualified after reset releases.
    for (int i = 0; i < 3; i++) hs("rst_pre", 8'h05, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hs("rst_held", 8'h05, 1'b1, 1'b0, 1'b1, 8'h0B, 2'd1, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) hs("rst_low", 8'h05, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hs("rst_requal", 8'h05, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0);
    hs("rst_act", 8'h05, 1'b1, 1'b0, 1'b1, 8'h0B, 2'd1, 8'h00, 1'b0, 1'b0);
    hs("rst_rel", 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 2'd1, 8'h00, 1'b0, 1'b0);

    // Random keys with sticky holds against the queue model.
    model_step(8'h00, 1'b1, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    check_out("rand_rst", m_val(), 2'(m_q.size()), m_res, m_sub, m_rej);
    kc = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) >= 75) kc = pool[$urandom_range(14)];
      en  = ($urandom_range(9) != 0);
      clr = ($urandom_range(49) == 0);
      rst = ($urandom_range(299) != 0);
      model_step(kc, en, clr, rst);
      drive(kc, en, clr, rst);
      check_out($sformatf("rand[%0d]", c), m_val(), 2'(m_q.size()), m_res, m_sub, m_rej);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
